// File: rtl/alu_issue_if.sv
// Bundle of the decode-side and alu-side signals of the execute-stage issue unit.
// Handshake rule for both channels: a transfer happens on a rising clock edge where
// valid and ready are both high; valid and the payload must stay stable until it does,
// and ready never depends combinationally on valid.
interface alu_issue_if #(
  parameter int WIDTH = 64
);
  // decode -> issue
  logic             op_valid_i;
  logic             op_ready_o;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] rs1_i;
  logic [WIDTH-1:0] rs2_i;
  logic [WIDTH-1:0] imm_i;
  logic             use_imm_i;
  // issue -> alu / writeback
  logic             issue_valid_o;
  logic             issue_ready_i;
  logic [WIDTH-1:0] inA_o;
  logic [WIDTH-1:0] inB_o;
  logic             cflag_o;
  logic             sum_en_o;
  logic             and_en_o;
  logic             alu_cflag_i;
  // status
  logic             carry_o;
  logic             err_o;

  // issue unit side
  modport slave (
    input  op_valid_i, op_i, rs1_i, rs2_i, imm_i, use_imm_i,
    input  issue_ready_i, alu_cflag_i,
    output op_ready_o, issue_valid_o, inA_o, inB_o, cflag_o, sum_en_o, and_en_o,
    output carry_o, err_o
  );

  // decode / alu / writeback side
  modport master (
    output op_valid_i, op_i, rs1_i, rs2_i, imm_i, use_imm_i,
    output issue_ready_i, alu_cflag_i,
    input  op_ready_o, issue_valid_o, inA_o, inB_o, cflag_o, sum_en_o, and_en_o,
    input  carry_o, err_o
  );
endinterface

// File: rtl/alu_issue.sv
// Execute-stage operand issue unit: 2-entry in-order buffer of micro-ops, head decode
// onto the alu controls, and ownership of the architectural carry flag.
module alu_issue #(
  parameter int WIDTH = 64
) (
  input logic       clk_i,
  input logic       reset_i,
  alu_issue_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_ADDC  = 3'b010,
    OP_SUBC  = 3'b011,
    OP_AND   = 3'b100,
    OP_PASSB = 3'b101,
    OP_SETC  = 3'b110,
    OP_ILL   = 3'b111
  } op_e;

  // buffer storage: opcode, A source, B operand already muxed between rs2 and imm
  logic [2:0]       r_op [2];
  logic [WIDTH-1:0] r_a  [2];
  logic [WIDTH-1:0] r_b  [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             r_carry;
  // set while a SETC/illegal head is spending its one cycle at the head
  logic             r_wait;

  logic             w_empty;
  logic             w_full;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_sel;
  op_e              w_head_op;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;
  logic             w_special;
  logic             w_issue;
  logic             w_fire;
  logic             w_auto_retire;
  logic             w_retire;
  logic [WIDTH-1:0] w_in_a;
  logic [WIDTH-1:0] w_in_b;
  logic             w_cin;
  logic             w_sum_en;
  logic             w_and_en;

  assign w_empty   = (r_count == 2'd0);
  assign w_full    = (r_count == 2'd2);
  // ready comes only from the registered count, never from issue_ready_i
  assign w_accept  = bus.op_valid_i & ~w_full;
  assign w_b_sel   = bus.use_imm_i ? bus.imm_i : bus.rs2_i;

  assign w_head_op = op_e'(r_op[r_rd_ptr]);
  assign w_head_a  = r_a[r_rd_ptr];
  assign w_head_b  = r_b[r_rd_ptr];

  assign w_special     = ~w_empty & ((w_head_op == OP_SETC) | (w_head_op == OP_ILL));
  assign w_issue       = ~w_empty & ~w_special;
  assign w_fire        = w_issue & bus.issue_ready_i;
  assign w_auto_retire = w_special & r_wait;
  assign w_retire      = w_fire | w_auto_retire;

  // buffer write/read pointers and occupancy
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 2; i++) begin
        r_op[i] <= 3'b000;
        r_a[i]  <= '0;
        r_b[i]  <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_accept) begin
        r_op[r_wr_ptr] <= bus.op_i;
        r_a[r_wr_ptr]  <= bus.rs1_i;
        r_b[r_wr_ptr]  <= w_b_sel;
        r_wr_ptr       <= ~r_wr_ptr;
      end
      if (w_retire) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // SETC/illegal heads sit at the head for one cycle, then retire on their own
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wait <= 1'b0;
    end else begin
      r_wait <= w_special & ~w_retire;
    end
  end

  // architectural carry: SETC forces it, arithmetic ops take the alu carry-out
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_carry <= 1'b0;
    end else if (w_auto_retire && (w_head_op == OP_SETC)) begin
      r_carry <= 1'b1;
    end else if (w_fire && !w_head_op[2]) begin
      r_carry <= bus.alu_cflag_i;
    end
  end

  // head decode onto alu controls; everything quiet when no issuable head
  always_comb begin
    w_in_a   = '0;
    w_in_b   = '0;
    w_cin    = 1'b0;
    w_sum_en = 1'b0;
    w_and_en = 1'b0;
    if (w_issue) begin
      case (w_head_op)
        OP_ADD:   begin w_in_a = w_head_a; w_in_b = w_head_b;                    w_sum_en = 1'b1; end
        OP_SUB:   begin w_in_a = w_head_a; w_in_b = ~w_head_b; w_cin = 1'b1;     w_sum_en = 1'b1; end
        OP_ADDC:  begin w_in_a = w_head_a; w_in_b = w_head_b;  w_cin = r_carry;  w_sum_en = 1'b1; end
        OP_SUBC:  begin w_in_a = w_head_a; w_in_b = ~w_head_b; w_cin = r_carry;  w_sum_en = 1'b1; end
        OP_AND:   begin w_in_a = w_head_a; w_in_b = w_head_b;                    w_and_en = 1'b1; end
        OP_PASSB: begin w_in_a = '1;       w_in_b = w_head_b;                    w_and_en = 1'b1; end
        default:  begin end
      endcase
    end
  end

  assign bus.op_ready_o    = ~w_full;
  assign bus.issue_valid_o = w_issue;
  assign bus.inA_o         = w_in_a;
  assign bus.inB_o         = w_in_b;
  assign bus.cflag_o       = w_cin;
  assign bus.sum_en_o      = w_sum_en;
  assign bus.and_en_o      = w_and_en;
  assign bus.carry_o       = r_carry;
  assign bus.err_o         = w_auto_retire & (w_head_op == OP_ILL);

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus randomized traffic, with a simple alu
// model closing the carry loop and a scoreboard of accepted ops.
module tb_alu_issue;
  localparam int W  = 64;
  localparam int EW = 3 + 2 * W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if #(.WIDTH(W)) bus ();

  alu_issue #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  // stand-in for the downstream alu
  logic [W:0]   alu_sum;
  logic [W-1:0] alu_out;
  always_comb begin
    alu_sum = {1'b0, bus.inA_o} + {1'b0, bus.inB_o} + {{W{1'b0}}, bus.cflag_o};
    alu_out = bus.sum_en_o ? alu_sum[W-1:0] : (bus.and_en_o ? (bus.inA_o & bus.inB_o) : '0);
  end
  assign bus.alu_cflag_i = alu_sum[W];

  // ---------------- scoreboard state ----------------
  int errors     = 0;
  int checks     = 0;
  int err_seen   = 0;
  int n_ill_sent = 0;
  int ready_mode = 1;   // 0: stall, 1: always ready, 2: random
  logic model_carry = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference: result, new carry and expected alu controls from plain arithmetic
  function automatic void ref_exec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, output logic [W-1:0] res, output logic c_new,
                                   output logic cin, output logic sum_en, output logic and_en);
    logic [W:0] wide;
    wide   = '0;
    res    = '0;
    c_new  = c;
    cin    = 1'b0;
    sum_en = (op <= 3'd3);
    and_en = (op == 3'd4) || (op == 3'd5);
    case (op)
      3'd0: begin wide = {1'b0, a} + {1'b0, b}; res = wide[W-1:0]; c_new = wide[W]; end
      3'd1: begin res = a - b; c_new = (a >= b); cin = 1'b1; end
      3'd2: begin wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c}; res = wide[W-1:0]; c_new = wide[W]; cin = c; end
      3'd3: begin res = a - b - {{(W-1){1'b0}}, ~c}; c_new = (({1'b0, a} + {{W{1'b0}}, c}) > {1'b0, b}); cin = c; end
      3'd4: res = a & b;
      3'd5: res = b;
      default: ;
    endcase
  endfunction

  // SETC entries retire invisibly; account for them when something younger shows up
  task automatic drop_setc();
    logic [EW-1:0] e;
    while (exp_q.size() > 0 && exp_q[0][EW-1 -: 3] == 3'd6) begin
      e = exp_q.pop_front();
      model_carry = 1'b1;
    end
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] m_e;
  logic [2:0]    m_op;
  logic [W-1:0]  m_a, m_b, m_res;
  logic          m_cnew, m_cin, m_sum, m_and;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.err_o) begin
        err_seen++;
        drop_setc();
        if (exp_q.size() == 0) check("err_unexpected", 1, 0);
        else begin
          m_e = exp_q.pop_front();
          check("err_op", m_e[EW-1 -: 3], 3'd7);
        end
      end
      if (bus.issue_valid_o && bus.issue_ready_i) begin
        drop_setc();
        if (exp_q.size() == 0) check("issue_unexpected", 1, 0);
        else begin
          m_e  = exp_q.pop_front();
          m_op = m_e[EW-1 -: 3];
          m_a  = m_e[2*W-1 -: W];
          m_b  = m_e[W-1:0];
          ref_exec(m_op, m_a, m_b, model_carry, m_res, m_cnew, m_cin, m_sum, m_and);
          check("issue_kind", (m_op[2] & m_op[1]), 0);
          check("issue_res", alu_out, m_res);
          check("issue_cflag", bus.cflag_o, m_cin);
          check("issue_sum_en", bus.sum_en_o, m_sum);
          check("issue_and_en", bus.and_en_o, m_and);
          check("issue_carry", bus.carry_o, model_carry);
          model_carry = m_cnew;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    bus.issue_ready_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        0:       bus.issue_ready_i = 1'b0;
        1:       bus.issue_ready_i = 1'b1;
        default: bus.issue_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  // call at posedge+1; returns at posedge+1 of the accepting edge
  task automatic send_op(input logic [2:0] op, input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                         input logic [W-1:0] imm, input logic use_imm);
    int n = 0;
    bus.op_valid_i = 1'b1;
    bus.op_i       = op;
    bus.rs1_i      = rs1;
    bus.rs2_i      = rs2;
    bus.imm_i      = imm;
    bus.use_imm_i  = use_imm;
    @(negedge clk);
    while (!bus.op_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.op_ready_o) begin
      check("send_timeout", 0, 1);
      bus.op_valid_i = 1'b0;
      return;
    end
    exp_q.push_back({op, rs1, use_imm ? imm : rs2});
    if (op == 3'd7) n_ill_sent++;
    @(posedge clk); #1;
    bus.op_valid_i = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [W-1:0] a_rs1, a_b;
  int n;
  initial begin
    // test 1: reset held with a valid op waiting
    bus.op_valid_i = 1'b1;
    bus.op_i       = 3'd0;
    bus.rs1_i      = 64'd1;
    bus.rs2_i      = 64'd2;
    bus.imm_i      = '0;
    bus.use_imm_i  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_issue_valid", bus.issue_valid_o, 0);
      check("rst_op_ready", bus.op_ready_o, 1);
      check("rst_carry", bus.carry_o, 0);
    end
    check("rst_alu_ab", bus.inA_o | bus.inB_o, 0);
    check("rst_ctl", {bus.cflag_o, bus.sum_en_o, bus.and_en_o, bus.err_o}, 0);
    exp_q.push_back({3'd0, 64'd1, 64'd2});
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.op_valid_i = 1'b0;
    // test 2: ADD 1+2 at head one cycle after accept
    @(negedge clk);
    check("add_valid", bus.issue_valid_o, 1);
    check("add_inA", bus.inA_o, 64'd1);
    check("add_inB", bus.inB_o, 64'd2);
    check("add_cflag", bus.cflag_o, 0);
    check("add_sum_en", bus.sum_en_o, 1);

    // test 3: SUB 5 - imm 5
    sync();
    send_op(3'd1, 64'd5, 64'd99, 64'd5, 1'b1);
    @(negedge clk);
    check("sub_inB", bus.inB_o, 64'hFFFF_FFFF_FFFF_FFFA);
    check("sub_cflag", bus.cflag_o, 1);
    check("sub_out", alu_out, 0);
    repeat (2) @(negedge clk);
    check("sub_carry", bus.carry_o, 1);

    // test 4: ADD all-ones + 1 then ADDC 0+0 back-to-back
    sync();
    send_op(3'd0, '1, 64'd1, '0, 1'b0);
    send_op(3'd2, '0, '0, '0, 1'b0);
    @(negedge clk);
    check("addc_cflag", bus.cflag_o, 1);
    check("addc_out", alu_out, 64'd1);

    // test 5: stall with three ops offered
    repeat (2) @(negedge clk);
    sync();
    ready_mode = 0;
    a_rs1 = {$urandom, $urandom};
    a_b   = {$urandom, $urandom};
    send_op(3'd4, a_rs1, a_b, '0, 1'b0);
    send_op(3'd0, 64'd7, 64'd8, '0, 1'b0);
    bus.op_valid_i = 1'b1;
    bus.op_i       = 3'd5;
    repeat (4) begin
      @(negedge clk);
      check("stall_op_ready", bus.op_ready_o, 0);
      check("stall_valid", bus.issue_valid_o, 1);
      check("stall_inA", bus.inA_o, a_rs1);
      check("stall_inB", bus.inB_o, a_b);
    end
    sync();
    ready_mode = 1;
    fork
      send_op(3'd5, 64'd3, 64'h55, '0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("release_valid", bus.issue_valid_o, 1);
        end
      end
    join

    // test 6: SETC, illegal, ADDC 0+0
    sync();
    send_op(3'd6, '0, '0, '0, 1'b0);
    send_op(3'd7, '0, '0, '0, 1'b0);
    send_op(3'd2, '0, '0, '0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!bus.err_o && n < 20) begin @(negedge clk); n++; end
    check("err_seen", bus.err_o, 1);
    @(negedge clk);
    check("err_width", bus.err_o, 0);
    n = 0;
    while (!(bus.issue_valid_o && bus.sum_en_o) && n < 20) begin @(negedge clk); n++; end
    check("setc_addc_cflag", bus.cflag_o, 1);
    check("setc_carry", bus.carry_o, 1);

    // reset mid-operation with ops buffered
    repeat (3) @(negedge clk);
    sync();
    ready_mode = 0;
    send_op(3'd6, '0, '0, '0, 1'b0);
    send_op(3'd4, 64'd1, 64'd1, '0, 1'b0);
    send_op(3'd0, 64'd1, 64'd1, '0, 1'b0);
    repeat (2) @(negedge clk);
    check("pre_rst_carry", bus.carry_o, 1);
    check("pre_rst_full", bus.op_ready_o, 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.issue_valid_o, 0);
    check("mid_rst_ready", bus.op_ready_o, 1);
    check("mid_rst_carry", bus.carry_o, 0);
    exp_q.delete();
    model_carry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", bus.issue_valid_o, 0);
    end

    // randomized traffic
    sync();
    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      send_op(3'($urandom_range(0, 7)), rand_val(), rand_val(), rand_val(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    ready_mode = 1;
    repeat (10) @(negedge clk);
    drop_setc();
    check("drain_empty", exp_q.size(), 0);
    check("drain_carry", bus.carry_o, model_carry);
    check("err_count", err_seen, n_ill_sent);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
